// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: hex font and segment bit positions.
package seg7_pkg;
  localparam logic [7:0] SEG_OFF_AH = 8'h00;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high gfedcba patterns; entry 15 first so HEX_FONT[n] selects digit n.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: value/dp/blanking controls in, digit select and segment pattern out.
interface seg7_scan_driver_if;
  logic        enable;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic        blank_lz;
  logic [2:0]  which;
  logic [7:0]  seg;

  modport master (output enable, data_in, dp_in, blank_lz, input which, seg);
  modport slave  (input enable, data_in, dp_in, blank_lz, output which, seg);
endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Nibble to active-high a..g segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] segs
);
  assign segs = HEX_FONT[nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes a 32-bit value as 8 hex digits; the value is latched once per frame
// on the 7->0 digit wrap so a frame never shows a mix of old and new data.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  seg7_scan_driver_if.slave dsp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [7:0] SEG_DARK = SEG_ACTIVE_LOW ? ~SEG_OFF_AH : SEG_OFF_AH;

  logic [DW-1:0] div;
  logic          tick;
  logic [2:0]    which_q, which_nx;
  logic [31:0]   sh_d, sh_d_nx;
  logic [7:0]    sh_dp, sh_dp_nx;
  logic          sh_blz, sh_blz_nx;
  logic          en_q;
  logic [7:0]    seg_q, seg_nx, pat;
  logic [7:0]    zhi;
  logic [3:0]    nib;
  logic [6:0]    font;
  logic          upd;

  assign tick = (div == DW'(SCAN_DIV - 1));

  always_comb begin
    which_nx  = which_q;
    sh_d_nx   = sh_d;
    sh_dp_nx  = sh_dp;
    sh_blz_nx = sh_blz;
    if (tick) begin
      which_nx = which_q + 3'd1;
      if (which_nx == 3'd0) begin
        sh_d_nx   = dsp.data_in;
        sh_dp_nx  = dsp.dp_in;
        sh_blz_nx = dsp.blank_lz;
      end
    end
  end

  // zhi[i]: nibbles i..7 of the shadow value are all zero
  always_comb begin
    logic z;
    z   = 1'b1;
    zhi = '0;
    for (int i = 7; i >= 0; i--) begin
      z      = z && (sh_d_nx[4*i +: 4] == 4'h0);
      zhi[i] = z;
    end
  end

  assign nib = sh_d_nx[{which_nx, 2'b00} +: 4];

  hex_to_seg7 u_font (.nib(nib), .segs(font));

  always_comb begin
    pat = SEG_OFF_AH;
    pat[SEG_G:SEG_A] = font;
    if (sh_blz_nx && (which_nx != 3'd0) && zhi[which_nx])
      pat[SEG_G:SEG_A] = 7'h00;
    pat[SEG_DP] = sh_dp_nx[which_nx];
    if (!dsp.enable)
      pat = SEG_OFF_AH;
    seg_nx = SEG_ACTIVE_LOW ? ~pat : pat;
  end

  // seg only moves on a tick, on a disabled cycle, or the first cycle after re-enable
  assign upd = tick || !dsp.enable || !en_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div     <= '0;
      which_q <= 3'd7;
      sh_d    <= '0;
      sh_dp   <= '0;
      sh_blz  <= 1'b0;
      en_q    <= 1'b1;
      seg_q   <= SEG_DARK;
    end else begin
      div     <= tick ? '0 : div + 1'b1;
      which_q <= which_nx;
      sh_d    <= sh_d_nx;
      sh_dp   <= sh_dp_nx;
      sh_blz  <= sh_blz_nx;
      en_q    <= dsp.enable;
      if (upd) seg_q <= seg_nx;
    end
  end

  assign dsp.which = which_q;
  assign dsp.seg   = seg_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with SCAN_DIV=4, active-low segments.
module tb_seg7_scan_driver;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [2:0] w;
    logic [7:0] s;
  } exp_t;
  exp_t exp_q[$];

  logic [2:0] last_w;
  logic [7:0] last_s;
  logic       cur_en;

  seg7_scan_driver_if dif();

  seg7_scan_driver #(.SCAN_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dsp  (dif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [7:0] ref_seg(input logic [31:0] d, input logic [7:0] dp,
                                         input logic blz, input logic en, input int i);
    logic [3:0] n;
    logic [6:0] f;
    logic [7:0] p;
    n = d[4*i +: 4];
    case (n)
      4'h0: f = 7'h3F; 4'h1: f = 7'h06; 4'h2: f = 7'h5B; 4'h3: f = 7'h4F;
      4'h4: f = 7'h66; 4'h5: f = 7'h6D; 4'h6: f = 7'h7D; 4'h7: f = 7'h07;
      4'h8: f = 7'h7F; 4'h9: f = 7'h6F; 4'hA: f = 7'h77; 4'hB: f = 7'h7C;
      4'hC: f = 7'h39; 4'hD: f = 7'h5E; 4'hE: f = 7'h79; default: f = 7'h71;
    endcase
    if (blz && i > 0 && (d >> (4*i)) == 32'h0) f = 7'h00;
    p = {dp[i], f};
    if (!en) p = 8'h00;
    return ~p;
  endfunction

  // Drive one frame's inputs just after a tick on digit 7, then follow all 8 digits.
  task automatic frame(input logic [31:0] d, input logic [7:0] dp, input logic blz,
                       input logic en, input int chg_idx, input logic [31:0] chg_d);
    exp_t e;
    logic skip;
    skip = en && !cur_en;
    if (!en) last_s = 8'hFF;
    cur_en       = en;
    dif.enable   = en;
    dif.data_in  = d;
    dif.dp_in    = dp;
    dif.blank_lz = blz;
    for (int i = 0; i < 8; i++) begin
      e.w = 3'(i);
      e.s = ref_seg(d, dp, blz, en, i);
      exp_q.push_back(e);
    end
    for (int k = 0; k < 8; k++) begin
      for (int c = 1; c < DIV; c++) begin
        @(posedge clk); #1;
        chk("hold_which", dif.which, last_w);
        if (!(skip && k == 0)) chk("hold_seg", dif.seg, last_s);
      end
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("which", dif.which, e.w);
        chk("seg", dif.seg, e.s);
        last_w = e.w;
        last_s = e.s;
      end
      if (k == chg_idx) dif.data_in = chg_d;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    dif.enable   = 1'b1;
    dif.data_in  = 32'h0;
    dif.dp_in    = 8'h0;
    dif.blank_lz = 1'b0;
    cur_en       = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_which", dif.which, 3'd7);
      chk("rst_seg", dif.seg, 8'hFF);
    end
    rst_n  = 1'b1;
    last_w = 3'd7;
    last_s = 8'hFF;

    frame(32'h1234ABCD, 8'h00, 1'b0, 1'b1, -1, 32'h0);
    frame(32'h000000A0, 8'h00, 1'b1, 1'b1, -1, 32'h0);
    frame(32'h00000000, 8'h00, 1'b1, 1'b1, -1, 32'h0);
    frame(32'h11111111, 8'h00, 1'b0, 1'b1, 3, 32'h22222222);
    frame(32'h22222222, 8'h00, 1'b0, 1'b1, -1, 32'h0);
    frame(32'h00000000, 8'h04, 1'b1, 1'b1, -1, 32'h0);
    frame(32'h00000000, 8'h04, 1'b1, 1'b0, -1, 32'h0);
    frame(32'h1234ABCD, 8'h00, 1'b0, 1'b1, -1, 32'h0);

    // mid-frame reset while digit 5 is lit
    repeat (6 * DIV) @(posedge clk);
    #1;
    chk("pre_rst_which", dif.which, 3'd5);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_which", dif.which, 3'd7);
    chk("midrst_seg", dif.seg, 8'hFF);
    rst_n  = 1'b1;
    last_w = 3'd7;
    last_s = 8'hFF;
    frame(32'h0000F00F, 8'h81, 1'b1, 1'b1, -1, 32'h0);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream display stage of CPU_Main. Takes the 32-bit value the CPU core selects for display (PC, register, ALU result) and time-multiplexes it as 8 hex digits onto the board's seven-segment bank through `which[2:0]` (digit select, externally decoded) and `seg[7:0]`. The displayed value is latched once per scan frame, so a digit never changes partway through a frame (no tearing).

Parameters:
SCAN_DIV, 100000, clk cycles each digit stays lit; legal range >= 2; sims use 4
SEG_ACTIVE_LOW, 1, 1 = segment/dp lit when its bit is 0 (board default); 0 = lit when 1

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset
enable  input  1  1 = display on; 0 = all segments and dp dark
data_in  input  32  value to display; nibble i drives digit i (digit 0 = rightmost)
dp_in  input  8  dp_in[i] lights the decimal point of digit i
blank_lz  input  1  1 = blank leading-zero digits
which  output  3  index of the currently lit digit
seg  output  8  seg[0..6] = segments a..g, seg[7] = dp; polarity set by SEG_ACTIVE_LOW

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - divider = 0; which = 3'd7; shadow data/dp/blank_lz = 0
  - seg = all-dark (8'hFF when SEG_ACTIVE_LOW = 1, 8'h00 otherwise)
  - Reset mid-frame aborts the frame immediately; no partial state survives.
- Divider: counts 0..SCAN_DIV-1, then wraps. "tick" = the edge where the divider is SCAN_DIV-1. It free-runs regardless of enable.
- On tick:
  - which <= which + 1 (mod 8; 7 wraps to 0).
  - When the new which is 0, the shadow registers load data_in, dp_in and blank_lz on that same edge. seg for digit 0 is computed from the freshly loaded values.
  - First tick after reset is at cycle SCAN_DIV. It selects digit 0 with a fresh latch.
- Output timing:
  - which and seg are both registered and change on the same edge.
  - Between ticks they hold their values.
  - Inputs that change mid-frame have no effect until the next 7->0 wrap.
- Digit content:
  - nib = shadow[4*which +: 4]; segments a..g come from the hex font.
  - Hex font (active-high, gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Leading-zero blanking:
  - Applies when shadow blank_lz = 1.
  - Digit i (i >= 1) shows a..g dark if all nibbles i..7 are zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Decimal point: dp = shadow dp[which], independent of blanking.
- enable = 0: seg forced all-dark on the next edge; which keeps scanning. Re-asserting enable restores normal output on the next edge.
- Polarity: when SEG_ACTIVE_LOW = 1, the final 8-bit pattern is inverted.
- Simultaneous events: reset dominates tick. A tick on the same edge as an enable change uses the new enable value.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry hex font constant
  - SEG_OFF_AH = 8'h00
  - the bit index localparams SEG_A..SEG_G and SEG_DP
- One combinational sub-module, hex_to_seg7: 4-bit nibble in, active-high 7-bit a..g out, built from the package font.
- Divider, digit counter, shadow latch, blanking and polarity logic stay in seg7_scan_driver.

Test Plan:
1. SCAN_DIV=4, rst_n low 2 cycles, then high -> which=7 and seg=8'hFF through cycle 3; at cycle 4 which=0; which then steps 0..7 every 4 cycles and wraps to 0.
2. data_in=32'h1234ABCD, dp_in=0, blank_lz=0, enable=1 -> seg per digit 0..7 = ~{0,5E}, ~{0,39}, ~{0,7C}, ~{0,77}, ~{0,66}, ~{0,4F}, ~{0,5B}, ~{0,06}, i.e. 8'hA1, C6, 83, 88, 99, B0, A4, F9.
3. data_in=32'h000000A0, blank_lz=1 -> digit0 = 8'hC0 ("0"), digit1 = 8'h88 ("A"), digits 2..7 = 8'hFF; data_in=0 -> only digit0 lit (8'hC0).
4. Change data_in from 32'h11111111 to 32'h22222222 while which=3 -> digits 3..7 still show "1" (8'hF9); new value appears only from the next which=0 onward.
5. dp_in=8'h04 with blank_lz=1 and data_in=0 -> digit 2 seg = 8'h7F (dp lit, segments blank); enable=0 -> seg=8'hFF on the next edge while which keeps advancing.
6. Assert rst_n low while which=5 mid-count -> next edge gives which=7 and seg=8'hFF; after release, the first tick arrives exactly SCAN_DIV cycles later.
